// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with sub-word load formatting and writeback source select.
// Optional retired-instruction counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_regWrite,
  input  logic              in_memToReg,
  input  logic              in_link,
  input  logic [2:0]        in_loadType,
  input  logic [1:0]        in_addrLow,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_memData,
  input  logic [DATA_W-1:0] in_pcPlus8,
  input  logic [4:0]        in_destReg,
  output logic [4:0]        writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  output logic              wbValid,
  output logic [31:0]       retireCount
);

  localparam logic [2:0] LdLw  = 3'b000;
  localparam logic [2:0] LdLh  = 3'b001;
  localparam logic [2:0] LdLhu = 3'b010;
  localparam logic [2:0] LdLb  = 3'b011;
  localparam logic [2:0] LdLbu = 3'b100;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_fmt;
  logic [DATA_W-1:0] wb_src;
  logic              capture;

  logic [4:0]        write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              reg_write_q, reg_write_d;
  logic              wb_valid_q, wb_valid_d;

  // Big-endian lane selection: offset 0 is the most significant byte.
  always_comb begin
    byte_sel = in_memData[31:24];
    unique case (in_addrLow)
      2'd0: byte_sel = in_memData[31:24];
      2'd1: byte_sel = in_memData[23:16];
      2'd2: byte_sel = in_memData[15:8];
      2'd3: byte_sel = in_memData[7:0];
      default: byte_sel = in_memData[31:24];
    endcase
    half_sel = in_addrLow[1] ? in_memData[15:0] : in_memData[31:16];
  end

  always_comb begin
    load_fmt = in_memData;
    case (in_loadType)
      LdLh:    load_fmt = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LdLhu:   load_fmt = {{(DATA_W-16){1'b0}}, half_sel};
      LdLb:    load_fmt = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LdLbu:   load_fmt = {{(DATA_W-8){1'b0}}, byte_sel};
      LdLw:    load_fmt = in_memData;
      default: load_fmt = in_memData;
    endcase
  end

  always_comb begin
    if (in_link) begin
      wb_src = in_pcPlus8;
    end else if (in_memToReg) begin
      wb_src = load_fmt;
    end else begin
      wb_src = in_aluResult;
    end
  end

  assign capture = ~flush & ~stall;

  always_comb begin
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    reg_write_d  = reg_write_q;
    wb_valid_d   = wb_valid_q;
    if (flush) begin
      write_addr_d = '0;
      write_data_d = '0;
      reg_write_d  = 1'b0;
      wb_valid_d   = 1'b0;
    end else if (!stall) begin
      write_addr_d = in_destReg;
      write_data_d = wb_src;
      // r0 is hardwired to zero, so writes to it never reach the bank.
      reg_write_d  = in_valid & in_regWrite & (|in_destReg);
      wb_valid_d   = in_valid;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_addr_q <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
    end else begin
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
      wb_valid_q   <= wb_valid_d;
    end
  end

  assign writeAddr = write_addr_q;
  assign writeData = write_data_q;
  assign regWrite  = reg_write_q;
  assign wbValid   = wb_valid_q;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (capture && in_valid) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retireCount = retire_cnt_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign retireCount    = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver queues expected WB state, monitor checks at negedge.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_regWrite = 1'b0, in_memToReg = 1'b0, in_link = 1'b0;
  logic [2:0]  in_loadType = 3'd0;
  logic [1:0]  in_addrLow = 2'd0;
  logic [31:0] in_aluResult = '0, in_memData = '0, in_pcPlus8 = '0;
  logic [4:0]  in_destReg = '0;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        regWrite, wbValid;
  logic [31:0] retireCount;

  typedef struct packed {
    logic        wbv;
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cnt_model = '0;

  mem_wb_stage #(.DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_regWrite (in_regWrite),
    .in_memToReg (in_memToReg),
    .in_link     (in_link),
    .in_loadType (in_loadType),
    .in_addrLow  (in_addrLow),
    .in_aluResult(in_aluResult),
    .in_memData  (in_memData),
    .in_pcPlus8  (in_pcPlus8),
    .in_destReg  (in_destReg),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .regWrite    (regWrite),
    .wbValid     (wbValid),
    .retireCount (retireCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every negedge the outputs reflect the preceding rising-edge capture.
  always @(negedge clock) begin
    if (reset && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("wbValid", {31'd0, wbValid}, {31'd0, e.wbv});
      check("regWrite", {31'd0, regWrite}, {31'd0, e.rw});
      check("writeAddr", {27'd0, writeAddr}, {27'd0, e.addr});
      check("writeData", writeData, e.data);
      check("retireCount", retireCount, e.cnt);
    end
  end

  // Drive one cycle of inputs just after the negedge and queue the expected result.
  task automatic vec(input logic st, input logic fl, input logic v, input logic rw,
                     input logic m2r, input logic lk, input logic [2:0] lt,
                     input logic [1:0] al, input logic [31:0] alu, input logic [31:0] mem,
                     input logic [31:0] pc, input logic [4:0] dst,
                     input logic e_wbv, input logic e_rw, input logic [4:0] e_addr,
                     input logic [31:0] e_data);
    exp_t e;
    @(negedge clock);
    #1;
    stall = st; flush = fl; in_valid = v; in_regWrite = rw; in_memToReg = m2r;
    in_link = lk; in_loadType = lt; in_addrLow = al; in_aluResult = alu;
    in_memData = mem; in_pcPlus8 = pc; in_destReg = dst;
`ifdef MEM_WB_RETIRE_CNT_EN
    if (!fl && !st && v) cnt_model = cnt_model + 32'd1;
`endif
    e.wbv = e_wbv; e.rw = e_rw; e.addr = e_addr; e.data = e_data; e.cnt = cnt_model;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
  endtask

  localparam logic [31:0] Mem = 32'h80F17F01;

  initial begin
    #3;
    check("rst_wbValid", {31'd0, wbValid}, 32'd0);
    check("rst_regWrite", {31'd0, regWrite}, 32'd0);
    check("rst_writeData", writeData, 32'd0);
    check("rst_retireCount", retireCount, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Load formatting (st fl v rw m2r lk lt al alu mem pc dst | wbv rw addr data)
    vec(0, 0, 1, 1, 1, 0, 3'd3, 2'd0, 32'h0, Mem, 32'h0, 5'd5, 1, 1, 5'd5, 32'hFFFFFF80);
    vec(0, 0, 1, 1, 1, 0, 3'd4, 2'd1, 32'h0, Mem, 32'h0, 5'd5, 1, 1, 5'd5, 32'h000000F1);
    vec(0, 0, 1, 1, 1, 0, 3'd1, 2'd2, 32'h0, Mem, 32'h0, 5'd5, 1, 1, 5'd5, 32'h00007F01);
    vec(0, 0, 1, 1, 1, 0, 3'd2, 2'd0, 32'h0, Mem, 32'h0, 5'd5, 1, 1, 5'd5, 32'h000080F1);
    vec(0, 0, 1, 1, 1, 0, 3'd0, 2'd3, 32'h0, Mem, 32'h0, 5'd5, 1, 1, 5'd5, 32'h80F17F01);
    vec(0, 0, 1, 1, 1, 0, 3'd3, 2'd3, 32'h0, Mem, 32'h0, 5'd6, 1, 1, 5'd6, 32'h00000001);
    vec(0, 0, 1, 1, 1, 0, 3'd1, 2'd1, 32'h0, Mem, 32'h0, 5'd6, 1, 1, 5'd6, 32'hFFFF80F1);
    vec(0, 0, 1, 1, 1, 0, 3'd4, 2'd2, 32'h0, Mem, 32'h0, 5'd6, 1, 1, 5'd6, 32'h0000007F);
    vec(0, 0, 1, 1, 1, 0, 3'd7, 2'd1, 32'h0, Mem, 32'h0, 5'd6, 1, 1, 5'd6, 32'h80F17F01);
    vec(0, 0, 1, 1, 1, 0, 3'd2, 2'd3, 32'h0, Mem, 32'h0, 5'd6, 1, 1, 5'd6, 32'h00007F01);

    // Source priority and ALU path
    vec(0, 0, 1, 1, 1, 1, 3'd0, 2'd0, 32'h1234, Mem, 32'h00400010, 5'd31,
        1, 1, 5'd31, 32'h00400010);
    vec(0, 0, 1, 1, 0, 0, 3'd3, 2'd0, 32'h1234, Mem, 32'h00400010, 5'd9,
        1, 1, 5'd9, 32'h00001234);

    // r0 suppression, then invalid slot
    vec(0, 0, 1, 1, 0, 0, 3'd0, 2'd0, 32'h55, Mem, 32'h0, 5'd0, 1, 0, 5'd0, 32'h55);
    vec(0, 0, 0, 1, 0, 0, 3'd0, 2'd0, 32'h66, Mem, 32'h0, 5'd3, 0, 0, 5'd3, 32'h66);
    vec(0, 0, 1, 0, 0, 0, 3'd0, 2'd0, 32'h77, Mem, 32'h0, 5'd4, 1, 0, 5'd4, 32'h77);

    // Stall three cycles with changing inputs: outputs hold
    vec(0, 0, 1, 1, 0, 0, 3'd0, 2'd0, 32'hAAAA, Mem, 32'h0, 5'd7, 1, 1, 5'd7, 32'hAAAA);
    vec(1, 0, 1, 1, 0, 0, 3'd0, 2'd0, 32'hBBBB, Mem, 32'h0, 5'd8, 1, 1, 5'd7, 32'hAAAA);
    vec(1, 0, 0, 0, 1, 0, 3'd3, 2'd1, 32'hCCCC, Mem, 32'h0, 5'd9, 1, 1, 5'd7, 32'hAAAA);
    vec(1, 0, 1, 1, 0, 1, 3'd0, 2'd0, 32'hDDDD, Mem, 32'hEE, 5'd10, 1, 1, 5'd7, 32'hAAAA);

    // Stall and flush together: bubble, no count
    vec(1, 1, 1, 1, 0, 0, 3'd0, 2'd0, 32'h1111, Mem, 32'h0, 5'd11, 0, 0, 5'd0, 32'h0);
    vec(0, 1, 1, 1, 0, 0, 3'd0, 2'd0, 32'h2222, Mem, 32'h0, 5'd12, 0, 0, 5'd0, 32'h0);

    // Four valid captures for the counter
    for (int i = 0; i < 4; i++) begin
      vec(0, 0, 1, 1, 0, 0, 3'd0, 2'd0, 32'h100 + i, Mem, 32'h0, 5'd13,
          1, 1, 5'd13, 32'h100 + i);
    end
    drain();

    // Asynchronous reset mid-cycle while regWrite is high and a stall is active
    @(negedge clock);
    #1;
    stall = 1'b1;
    @(posedge clock);
    #2;
    check("pre_rst_regWrite", {31'd0, regWrite}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_wbValid", {31'd0, wbValid}, 32'd0);
    check("async_regWrite", {31'd0, regWrite}, 32'd0);
    check("async_writeAddr", {27'd0, writeAddr}, 32'd0);
    check("async_writeData", writeData, 32'd0);
    check("async_retireCount", retireCount, 32'd0);
    cnt_model = '0;
    @(negedge clock);
    #1;
    reset = 1'b1;

    // First capture after release
    vec(0, 0, 1, 1, 1, 0, 3'd3, 2'd1, 32'h0, Mem, 32'h0, 5'd2, 1, 1, 5'd2, 32'hFFFFFFF1);
    vec(0, 0, 1, 1, 0, 0, 3'd0, 2'd0, 32'hCAFE, Mem, 32'h0, 5'd2, 1, 1, 5'd2, 32'hCAFE);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
